fifo_write_arbiter: RTL

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter in front of a single-port FIFO: one requester owns the write
// port for a burst of up to MAXBURST words, then the grant rotates after one idle cycle.
module fifo_write_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned MAXBURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DWIDTH-1:0]   din,
  input  logic                     full,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     count,
  output logic [DWIDTH-1:0]        wdata
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BeatW = $clog2(MAXBURST) + 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(MAXBURST - 1);
  localparam logic [IdxW:0]    NreqW    = (IdxW + 1)'(NREQ);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   prio_q, prio_d;
  logic [BeatW-1:0]  beat_q, beat_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IdxW-1:0]   off;
  logic [IdxW:0]     pick_sum;
  logic [IdxW-1:0]   pick;
  logic [IdxW:0]     nxt_sum;
  logic [IdxW-1:0]   owner_nxt;
  logic              owner_req;
  logic              accept;

  // Rotate req so bit 0 is prio_ptr, take the lowest set bit, then rotate the index back.
  always_comb begin
    req_dbl = {req, req} >> prio_q;
    req_rot = req_dbl[NREQ-1:0];
    off     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = IdxW'(i);
    end
    pick_sum = {1'b0, prio_q} + {1'b0, off};
    if (pick_sum >= NreqW) pick_sum = pick_sum - NreqW;
    pick = pick_sum[IdxW-1:0];

    nxt_sum = {1'b0, owner_q} + {{IdxW{1'b0}}, 1'b1};
    if (nxt_sum >= NreqW) nxt_sum = '0;
    owner_nxt = nxt_sum[IdxW-1:0];
  end

  always_comb begin
    owner_req = 1'b0;
    wdata     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_req = req[i];
        if (state_q == StBurst) wdata = din[i*DWIDTH +: DWIDTH];
      end
    end
    accept = (state_q == StBurst) && owner_req && !full;
    count  = accept;
    ack    = accept ? gnt_q : '0;
    gnt    = gnt_q;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    beat_d  = beat_q;
    case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (|req) begin
          state_d = StBurst;
          owner_d = pick;
          beat_d  = '0;
          for (int i = 0; i < NREQ; i++) gnt_d[i] = (pick == IdxW'(i));
        end
      end
      StBurst: begin
        // A stalled beat never reaches the limit, so full only blocks the beat-limit release.
        if (!owner_req || (accept && (beat_q == BeatLast))) begin
          state_d = StIdle;
          gnt_d   = '0;
          prio_d  = owner_nxt;
          beat_d  = '0;
        end else if (accept) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      owner_q <= '0;
      prio_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      beat_q  <= beat_d;
    end
  end

endmodule
